// File: rtl/fifo_pkg.sv
// fifo_pkg
// Shared definitions for the synchronous FIFO slice: read-mode selectors,
// default sizing/threshold constants and a ceiling-log2 helper for callers
// that size a FIFO from a word count rather than an address width.
package fifo_pkg;

  // Read-mode selectors for the FWFT parameter of sync_fifo.
  localparam bit FWFT_OFF = 1'b0;
  localparam bit FWFT_ON  = 1'b1;

  // Default geometry and flag thresholds.
  localparam int DEF_ADDR_WIDTH    = 4;
  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_AFULL_MARGIN  = 2;
  localparam int DEF_AEMPTY_THRESH = 1;

  // Ceiling log2; clog2(1) = 0, clog2(16) = 4, clog2(17) = 5.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo_sdpram.sv
// sdpram
// Single-clock simple dual-port RAM: one write port, one read port with a
// registered output. The array itself has no reset; the read register only
// loads when re is high, so it holds its value between reads.
// Ports:
//   clk    posedge clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   re     read enable (loads rdata on the next edge)
//   raddr  read address
//   rdata  registered read data
module sdpram
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // A read of the address being written in the same cycle returns the old
  // word; the FIFO never issues such a read, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO on top of sdpram, with registered status flags,
// occupancy count, sticky error flags and a choice of standard or
// first-word-fall-through read behaviour.
// Ports:
//   clk        posedge clock
//   rstn       asynchronous active-low reset
//   wren       write request
//   wrdata     write data
//   full       no space left, writes are dropped
//   afull      count >= AFULL_THRESH
//   rden       read request (standard) / head acknowledge (FWFT)
//   rddata     read data
//   rdvalid    rddata valid (pulse in standard mode, level in FWFT mode)
//   empty      count == 0
//   aempty     count <= AEMPTY_THRESH
//   count      words held, including the FWFT output register
//   clrerr     synchronous clear of overflow/underflow
//   overflow   sticky: write attempted while full
//   underflow  sticky: read attempted with no data available
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - DEF_AFULL_MARGIN,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH,
  parameter bit FWFT          = FWFT_OFF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] wrdata,
  output logic                  full,
  output logic                  afull,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] rddata,
  output logic                  rdvalid,
  output logic                  empty,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  clrerr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count_q;
  logic [PW-1:0]         wr_ptr_nxt;
  logic [PW-1:0]         rd_ptr_nxt;
  logic [PW-1:0]         count_nxt;
  logic                  full_nxt;
  logic                  full_q;
  logic                  empty_q;
  logic                  afull_q;
  logic                  aempty_q;
  logic                  overflow_q;
  logic                  underflow_q;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  rd_err;
  logic                  ram_re;
  logic [ADDR_WIDTH-1:0] ram_raddr;
  logic [DATA_WIDTH-1:0] ram_q;

  // Writes are judged against the registered full flag only, so a read
  // in the same cycle never makes room for a write into a full FIFO.
  assign wr_acc = wren && !full_q;

  // Next pointer/count values. rd_acc comes from the mode-specific read
  // logic below: a RAM read in standard mode, a head pop in FWFT mode.
  always_comb begin
    wr_ptr_nxt = wr_ptr + {{ADDR_WIDTH{1'b0}}, wr_acc};
    rd_ptr_nxt = rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_acc};
    count_nxt  = count_q;
    if (wr_acc && !rd_acc) begin
      count_nxt = count_q + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count_q - 1'b1;
    end
    full_nxt = (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) &&
               (wr_ptr_nxt[PW-2:0] == rd_ptr_nxt[PW-2:0]);
  end

  // Pointers, count and all level flags are registered from the next-state
  // values so they change on the same edge as the accepted operation and
  // no output depends combinationally on wren/rden.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      count_q  <= count_nxt;
      full_q   <= full_nxt;
      empty_q  <= (wr_ptr_nxt == rd_ptr_nxt);
      afull_q  <= (count_nxt >= AFULL_LVL);
      aempty_q <= (count_nxt <= AEMPTY_LVL);
    end
  end

  // Sticky error flags. A new error in the same cycle as clrerr wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wren && full_q) begin
        overflow_q <= 1'b1;
      end else if (clrerr) begin
        overflow_q <= 1'b0;
      end
      if (rd_err) begin
        underflow_q <= 1'b1;
      end else if (clrerr) begin
        underflow_q <= 1'b0;
      end
    end
  end

  sdpram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (wrdata),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  generate
    if (FWFT == FWFT_ON) begin : g_fwft
      // Two-stage prefetch: the RAM read register (mid stage) feeds the
      // output register. rd_ptr tracks popped words for the flags, while
      // fetch_ptr tracks words already pulled out of the RAM array. Words
      // in flight still occupy their RAM slots, so full/empty stay exact.
      logic [PW-1:0]         fetch_ptr;
      logic                  mid_vld;
      logic                  out_vld;
      logic [DATA_WIDTH-1:0] out_data;
      logic                  pop;
      logic                  out_load;

      assign pop       = rden && out_vld;
      assign out_load  = mid_vld && (!out_vld || pop);
      // Refill the mid stage when it is empty or being drained this cycle,
      // which keeps rdvalid high across back-to-back pops.
      assign ram_re    = (fetch_ptr != wr_ptr) && (!mid_vld || out_load);
      assign ram_raddr = fetch_ptr[ADDR_WIDTH-1:0];
      assign rd_acc    = pop;
      assign rd_err    = rden && !out_vld;
      assign rddata    = out_data;
      assign rdvalid   = out_vld;

      // Prefetch pipeline state.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          fetch_ptr <= '0;
          mid_vld   <= 1'b0;
          out_vld   <= 1'b0;
          out_data  <= '0;
        end else begin
          if (ram_re) begin
            fetch_ptr <= fetch_ptr + 1'b1;
            mid_vld   <= 1'b1;
          end else if (out_load) begin
            mid_vld   <= 1'b0;
          end
          if (out_load) begin
            out_data <= ram_q;
            out_vld  <= 1'b1;
          end else if (pop) begin
            out_vld  <= 1'b0;
          end
        end
      end
    end else begin : g_std
      // Standard mode: the RAM read register is the output register.
      // seen_q masks the unreset RAM register until the first real read so
      // rddata reads as zero out of reset.
      logic rdvalid_q;
      logic seen_q;

      assign rd_acc    = rden && !empty_q;
      assign rd_err    = rden && empty_q;
      assign ram_re    = rd_acc;
      assign ram_raddr = rd_ptr[ADDR_WIDTH-1:0];
      assign rddata    = seen_q ? ram_q : '0;
      assign rdvalid   = rdvalid_q;

      // One-cycle valid pulse following each accepted read.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rdvalid_q <= 1'b0;
          seen_q    <= 1'b0;
        end else begin
          rdvalid_q <= rd_acc;
          if (rd_acc) begin
            seen_q <= 1'b1;
          end
        end
      end
    end
  endgenerate

  assign full      = full_q;
  assign empty     = empty_q;
  assign afull     = afull_q;
  assign aempty    = aempty_q;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo
// Directed bench for sync_fifo: a standard-mode instance (depth 4,
// afull at 3, aempty at 1) driven from a vector table plus hand-written
// wrap-around, simultaneous and reset sequences, and an FWFT instance of
// the same geometry for prefetch latency and back-to-back pops.
module tb_sync_fifo;
  import fifo_pkg::*;

  logic       clk;
  logic       rstn;

  logic       s_wren, s_rden, s_clrerr;
  logic [7:0] s_wrdata, s_rddata;
  logic       s_full, s_afull, s_empty, s_aempty, s_rdvalid, s_overflow, s_underflow;
  logic [2:0] s_count;

  logic       f_wren, f_rden, f_clrerr;
  logic [7:0] f_wrdata, f_rddata;
  logic       f_full, f_afull, f_empty, f_aempty, f_rdvalid, f_overflow, f_underflow;
  logic [2:0] f_count;

  int checks;
  int errors;

  typedef struct {
    logic       wren;
    logic [7:0] wrdata;
    logic       rden;
    logic       clrerr;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       afull;
    logic       aempty;
    logic       rdvalid;
    logic [7:0] rddata;
    logic       overflow;
    logic       underflow;
  } vec_t;

  vec_t vecs [14];

  sync_fifo #(
    .ADDR_WIDTH (2), .DATA_WIDTH (8), .AFULL_THRESH (3),
    .AEMPTY_THRESH (1), .FWFT (FWFT_OFF)
  ) dut_std (
    .clk (clk), .rstn (rstn), .wren (s_wren), .wrdata (s_wrdata),
    .full (s_full), .afull (s_afull), .rden (s_rden), .rddata (s_rddata),
    .rdvalid (s_rdvalid), .empty (s_empty), .aempty (s_aempty),
    .count (s_count), .clrerr (s_clrerr), .overflow (s_overflow),
    .underflow (s_underflow)
  );

  sync_fifo #(
    .ADDR_WIDTH (2), .DATA_WIDTH (8), .AFULL_THRESH (3),
    .AEMPTY_THRESH (1), .FWFT (FWFT_ON)
  ) dut_fwft (
    .clk (clk), .rstn (rstn), .wren (f_wren), .wrdata (f_wrdata),
    .full (f_full), .afull (f_afull), .rden (f_rden), .rddata (f_rddata),
    .rdvalid (f_rdvalid), .empty (f_empty), .aempty (f_aempty),
    .count (f_count), .clrerr (f_clrerr), .overflow (f_overflow),
    .underflow (f_underflow)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison with its own counter bookkeeping.
  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare every standard-instance output against the expected half of v.
  task automatic checkOutput(input string tag, input vec_t v, input bit chk_data);
    checkField({tag, ".count"},     32'(s_count),     32'(v.count));
    checkField({tag, ".full"},      32'(s_full),      32'(v.full));
    checkField({tag, ".empty"},     32'(s_empty),     32'(v.empty));
    checkField({tag, ".afull"},     32'(s_afull),     32'(v.afull));
    checkField({tag, ".aempty"},    32'(s_aempty),    32'(v.aempty));
    checkField({tag, ".rdvalid"},   32'(s_rdvalid),   32'(v.rdvalid));
    if (chk_data) begin
      checkField({tag, ".rddata"},  32'(s_rddata),    32'(v.rddata));
    end
    checkField({tag, ".overflow"},  32'(s_overflow),  32'(v.overflow));
    checkField({tag, ".underflow"}, 32'(s_underflow), 32'(v.underflow));
  endtask

  // Drive one vector's inputs on the falling edge, then sample 1 ns after
  // the next rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    s_wren   = v.wren;
    s_wrdata = v.wrdata;
    s_rden   = v.rden;
    s_clrerr = v.clrerr;
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle with whatever inputs are currently driven.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t rst_v;
    vec_t exp_v;

    checks = 0;
    errors = 0;

    // wren wrdata rden clrerr | count full empty afull aempty rdvalid rddata ovf udf
    vecs[0]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'hA2, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'hA3, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'hA4, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA2, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA4, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA4, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA4, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA4, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA4, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA4, 1'b0, 1'b0};

    rst_v = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};

    rstn = 1'b0;
    s_wren = 1'b0; s_rden = 1'b0; s_clrerr = 1'b0; s_wrdata = 8'h00;
    f_wren = 1'b0; f_rden = 1'b0; f_clrerr = 1'b0; f_wrdata = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset", rst_v, 1'b1);
    checkField("reset.f_rdvalid", 32'(f_rdvalid), 32'd0);
    checkField("reset.f_empty",   32'(f_empty),   32'd1);
    @(negedge clk);
    rstn = 1'b1;

    // Fill/overflow/drain/underflow/clrerr table on the standard instance.
    $display("[TB] standard-mode vector table");
    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("v%0d", i), vecs[i], 1'b1);
    end

    // Wrap-around: 12 words streamed through, one read trailing each write.
    $display("[TB] wrap-around stream");
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      s_clrerr = 1'b0;
      s_wren   = (i < 12);
      s_wrdata = 8'(i);
      s_rden   = (i > 0);
      stepCycle();
      checkField($sformatf("wrap%0d.count", i), 32'(s_count), (i < 12) ? 32'd1 : 32'd0);
      checkField($sformatf("wrap%0d.empty", i), 32'(s_empty), (i == 12) ? 32'd1 : 32'd0);
      checkField($sformatf("wrap%0d.full", i),  32'(s_full),  32'd0);
      checkField($sformatf("wrap%0d.rdvalid", i), 32'(s_rdvalid), (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) begin
        checkField($sformatf("wrap%0d.rddata", i), 32'(s_rddata), 32'(i - 1));
      end
    end

    // Simultaneous write+read at count 2 keeps count and order.
    $display("[TB] simultaneous read/write");
    @(negedge clk);
    s_rden = 1'b0; s_wren = 1'b1; s_wrdata = 8'hB0;
    @(negedge clk);
    s_wrdata = 8'hB1;
    stepCycle();
    checkField("sim.pre_count", 32'(s_count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_wren   = 1'b1;
      s_wrdata = 8'hB2 + 8'(i);
      s_rden   = 1'b1;
      stepCycle();
      checkField($sformatf("sim%0d.count", i),   32'(s_count),   32'd2);
      checkField($sformatf("sim%0d.rdvalid", i), 32'(s_rdvalid), 32'd1);
      checkField($sformatf("sim%0d.rddata", i),  32'(s_rddata),  32'(8'hB0 + 8'(i)));
    end
    @(negedge clk);
    s_rden = 1'b0; s_wrdata = 8'hC0;
    @(negedge clk);
    s_wrdata = 8'hC1;
    stepCycle();
    checkField("simfull.count", 32'(s_count), 32'd4);
    checkField("simfull.full",  32'(s_full),  32'd1);
    // At full: read accepted, write rejected.
    @(negedge clk);
    s_wren = 1'b1; s_wrdata = 8'hC2; s_rden = 1'b1;
    stepCycle();
    checkField("simfull.ovf",     32'(s_overflow), 32'd1);
    checkField("simfull.count2",  32'(s_count),    32'd3);
    checkField("simfull.full2",   32'(s_full),     32'd0);
    checkField("simfull.rddata",  32'(s_rddata),   32'hBA);

    // FWFT is covered before the reset sequence; the standard instance
    // simply idles meanwhile with its overflow flag still set.
    @(negedge clk);
    s_wren = 1'b0; s_rden = 1'b0;

    $display("[TB] FWFT latency and pops");
    @(negedge clk);
    f_wren = 1'b1; f_wrdata = 8'h5C;
    stepCycle();
    checkField("fw.n.count",   32'(f_count),   32'd1);
    checkField("fw.n.empty",   32'(f_empty),   32'd0);
    checkField("fw.n.rdvalid", 32'(f_rdvalid), 32'd0);
    @(negedge clk);
    f_wren = 1'b0;
    stepCycle();
    checkField("fw.n1.rdvalid", 32'(f_rdvalid), 32'd0);
    stepCycle();
    checkField("fw.n2.rdvalid", 32'(f_rdvalid), 32'd1);
    checkField("fw.n2.rddata",  32'(f_rddata),  32'h5C);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      f_wren = 1'b1; f_wrdata = 8'h61 + 8'(i);
    end
    @(negedge clk);
    f_wren = 1'b0;
    repeat (2) stepCycle();
    checkField("fw.fill.count",  32'(f_count),   32'd4);
    checkField("fw.fill.full",   32'(f_full),    32'd1);
    checkField("fw.fill.afull",  32'(f_afull),   32'd1);
    checkField("fw.fill.rddata", 32'(f_rddata),  32'h5C);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      f_rden = 1'b1;
      stepCycle();
      checkField($sformatf("fw.pop%0d.rdvalid", i), 32'(f_rdvalid), (i < 3) ? 32'd1 : 32'd0);
      checkField($sformatf("fw.pop%0d.count", i),   32'(f_count),   32'(3 - i));
      if (i < 3) begin
        checkField($sformatf("fw.pop%0d.rddata", i), 32'(f_rddata), 32'(8'h61 + 8'(i)));
      end
    end
    stepCycle();
    checkField("fw.udf",   32'(f_underflow), 32'd1);
    checkField("fw.empty", 32'(f_empty),     32'd1);
    @(negedge clk);
    f_rden = 1'b0; f_wren = 1'b1; f_wrdata = 8'h77;
    @(negedge clk);
    f_wren = 1'b0;
    repeat (3) stepCycle();
    checkField("fw.hold.rdvalid", 32'(f_rdvalid), 32'd1);
    checkField("fw.hold.rddata",  32'(f_rddata),  32'h77);

    // Reset mid-burst: refill the standard instance, read one word so
    // rdvalid is high, then drop rstn between edges.
    $display("[TB] asynchronous reset mid-burst");
    @(negedge clk);
    s_wren = 1'b1; s_wrdata = 8'hD0;
    @(negedge clk);
    s_wrdata = 8'hD1; s_rden = 1'b1;
    stepCycle();
    checkField("prerst.rdvalid", 32'(s_rdvalid), 32'd1);
    @(negedge clk);
    s_wrdata = 8'hD2; s_rden = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("midrst", rst_v, 1'b1);
    checkField("midrst.f_rdvalid", 32'(f_rdvalid),   32'd0);
    checkField("midrst.f_count",   32'(f_count),     32'd0);
    checkField("midrst.f_rddata",  32'(f_rddata),    32'd0);
    checkField("midrst.f_udf",     32'(f_underflow), 32'd0);
    @(negedge clk);
    s_wren = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // FIFO is usable again from a clean pointer state.
    @(negedge clk);
    s_wren = 1'b1; s_wrdata = 8'hE1;
    @(negedge clk);
    s_wren = 1'b0; s_rden = 1'b1;
    stepCycle();
    exp_v = '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hE1, 1'b0, 1'b0};
    checkOutput("postrst", exp_v, 1'b1);
    @(negedge clk);
    s_rden = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock FIFO built on a parametrised simple dual-port RAM (registered read).
- Generalises the team's two-port RAM:
  - full/empty/almost-full/almost-empty flags
  - occupancy count
  - sticky overflow/underflow error flags
  - selectable standard or first-word-fall-through (FWFT) read mode
- Used as the buffering stage between streaming producer/consumer logic in the sandbox designs.

Parameters:
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (min 1).
- DATA_WIDTH, 8, word width in bits.
- AFULL_THRESH, DEPTH-2, afull asserted when count >= AFULL_THRESH (range 1..DEPTH).
- AEMPTY_THRESH, 1, aempty asserted when count <= AEMPTY_THRESH (range 0..DEPTH-1).
- FWFT, 0, 0 = standard read mode, 1 = first-word-fall-through.

Ports:
- clk  in  1  posedge clock, all logic.
- rstn  in  1  asynchronous active-low reset.
- wren  in  1  write request.
- wrdata  in  DATA_WIDTH  write data.
- full  out  1  no space; writes rejected.
- afull  out  1  almost full.
- rden  in  1  read request (standard) / head-word acknowledge (FWFT).
- rddata  out  DATA_WIDTH  read data.
- rdvalid  out  1  rddata valid.
- empty  out  1  count == 0.
- aempty  out  1  almost empty.
- count  out  ADDR_WIDTH+1  words held (includes FWFT output register).
- clrerr  in  1  synchronous clear of error flags.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted with no data.

Behaviour:
- One clock domain; reset is asynchronous and active-low (rstn); all state is cleared on rstn low, released synchronously to clk.
- Reset values:
  - wr/rd pointers 0, count 0
  - empty 1, aempty 1, full 0, afull 0
  - rdvalid 0, rddata 0
  - overflow 0, underflow 0
  - RAM array not reset.
- Pointers are ADDR_WIDTH+1 bits and wrap modulo 2*DEPTH. full = MSBs differ and low bits equal; empty = pointers equal.
- Write accepted = wren && !full. A write while full is dropped: memory and pointer unchanged, overflow set.
- Standard mode (FWFT=0):
  - Read accepted = rden && !empty.
  - rddata updates and rdvalid pulses high exactly one cycle after the accepting edge (latency 1).
  - rdvalid is 0 otherwise; rddata holds its last value.
  - rden while empty sets underflow; rddata and rdvalid are unaffected.
- FWFT mode (FWFT=1):
  - The head word is prefetched into the output register; rdvalid=1 whenever it is present.
  - rden && rdvalid pops the head. The next word, if any, appears with rdvalid held high and no bubble.
  - Write into a completely empty FIFO at edge N: count=1 after N; rdvalid=1 with the word after N+2.
  - rden while rdvalid=0 sets underflow.
- Simultaneous accepted write and read: count unchanged, both pointers advance.
  - Write while full is rejected even if a read is accepted in the same cycle.
  - Read while empty is rejected even if a write is accepted in the same cycle.
- count, full, empty, afull and aempty are registered and update on the same edge as the accepted operation. No combinational path from wren/rden to any output.
- overflow/underflow are sticky until clrerr=1. If clrerr and a new error occur in the same cycle, the error wins (flag stays 1).
- Reset mid-operation: all flags and the count return to reset values immediately. Data in flight is discarded. rdvalid drops asynchronously.

Decomposition:
- Shared package fifo_pkg:
  - FWFT_OFF / FWFT_ON mode constants
  - clog2 helper function
  - default threshold constants
- Sub-module sdpram:
  - single clock, one write port, one registered read port
  - parameters ADDR_WIDTH / DATA_WIDTH
  - no array reset
- sync_fifo holds pointers, count, flags and the FWFT prefetch logic.

Test Plan:
- ADDR_WIDTH=2, FWFT=0, reset then write 0xA1,0xA2,0xA3,0xA4 → full=1 and count=4 after 4th edge. 5th write 0xA5 → overflow=1 and contents unchanged. Four reads → 0xA1..0xA4 each with a 1-cycle rdvalid pulse, then empty=1.
- FWFT=0, read on an empty FIFO → underflow=1 and rdvalid stays 0. clrerr pulse → underflow=0. clrerr coincident with a new underflow → underflow stays 1.
- Wrap-around: write and read continuously for 3*DEPTH words (0x00..0x0B) → output order exact, count never exceeds 4, no spurious full/empty.
- Simultaneous: at count=2, assert wren and rden together for 10 cycles → count stays 2, data order preserved. At full with wren and rden together → read accepted, write rejected, overflow=1.
- FWFT=1, write 0x5C into an empty FIFO at edge N → rdvalid=1 with rddata=0x5C after N+2. Back-to-back pops of 4 words → rdvalid stays high with no bubble.
- Thresholds AFULL_THRESH=3, AEMPTY_THRESH=1: fill 0→4 → afull rises at count=3, aempty falls at count=2. Assert rstn=0 mid-burst → all outputs return to reset values before the next clk edge.
